// File: rtl/y_monitor_pkg.sv
// Shared types and default parameters for the y event monitor slice.
package y_monitor_pkg;

  // Report FSM: counting events, or holding a snapshot for the consumer
  typedef enum logic [0:0] {
    COUNT  = 1'b0,
    REPORT = 1'b1
  } mon_state_e;

  localparam int DEBOUNCE_DEF = 4;
  localparam int COUNT_W_DEF  = 8;
  localparam int THRESH_DEF   = 10;

endpackage

// File: rtl/debounce_filter.sv
// Two-flop synchronizer, stability-counter debounce and rising-edge pulse
// for the asynchronous y input.
module debounce_filter
  import y_monitor_pkg::*;
#(
  parameter int DEBOUNCE = DEBOUNCE_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic y_in,
  output logic filt,
  output logic edge_pulse
);

  // Counter must be able to hold DEBOUNCE-1; one extra bit keeps DEBOUNCE=1 legal.
  localparam int SW = $clog2(DEBOUNCE + 1);
  localparam logic [SW-1:0] STAB_LAST = SW'(DEBOUNCE - 1);

  logic [1:0]    sync_reg;
  logic          y_s;
  logic [SW-1:0] stab_reg;
  logic          filt_reg;
  logic          edge_reg;

  assign y_s = sync_reg[1];

  // Two-stage synchronizer on the raw input
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_reg <= 2'b00;
    end else begin
      sync_reg <= {sync_reg[0], y_in};
    end
  end

  // Filtered level flips only after DEBOUNCE consecutive disagreeing samples;
  // the edge pulse is raised in the same cycle the level goes high.
  always_ff @(posedge clk) begin
    if (rst) begin
      stab_reg <= '0;
      filt_reg <= 1'b0;
      edge_reg <= 1'b0;
    end else begin
      edge_reg <= 1'b0;
      if (y_s == filt_reg) begin
        stab_reg <= '0;
      end else if (stab_reg == STAB_LAST) begin
        stab_reg <= '0;
        filt_reg <= ~filt_reg;
        edge_reg <= ~filt_reg;
      end else begin
        stab_reg <= stab_reg + SW'(1);
      end
    end
  end

  assign filt       = filt_reg;
  assign edge_pulse = edge_reg;

endmodule

// File: rtl/y_event_monitor.sv
// Counts debounced rising edges of y and hands out a snapshot through a
// valid/ready port every THRESH events; flags events lost while a report waits.
module y_event_monitor
  import y_monitor_pkg::*;
#(
  parameter int DEBOUNCE = DEBOUNCE_DEF,
  parameter int COUNT_W  = COUNT_W_DEF,
  parameter int THRESH   = THRESH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               y_in,
  input  logic               clear,
  output logic               filt,
  output logic               edge_pulse,
  output logic [COUNT_W-1:0] count,
  output logic               report_valid,
  input  logic               report_ready,
  output logic [COUNT_W-1:0] report_count,
  output logic               overrun
);

  localparam logic [COUNT_W-1:0] CNT_LAST = COUNT_W'(THRESH - 1);
  localparam logic [COUNT_W-1:0] CNT_FULL = COUNT_W'(THRESH);

  mon_state_e         state_reg, state_next;
  logic [COUNT_W-1:0] count_reg, count_next;
  logic [COUNT_W-1:0] rcount_reg, rcount_next;
  logic               valid_reg, valid_next;
  logic               ovr_reg, ovr_next;
  logic               accept;
  logic               at_last;

  debounce_filter #(
    .DEBOUNCE (DEBOUNCE)
  ) u_debounce (
    .clk        (clk),
    .rst        (rst),
    .y_in       (y_in),
    .filt       (filt),
    .edge_pulse (edge_pulse)
  );

  assign accept  = valid_reg & report_ready;
  assign at_last = (count_reg == CNT_LAST);

  // Next-state logic: counting, report issue/reload, overrun and soft clear
  always_comb begin
    state_next  = state_reg;
    count_next  = count_reg;
    rcount_next = rcount_reg;
    valid_next  = valid_reg;
    ovr_next    = ovr_reg;
    if (clear) begin
      // Clear wins over any edge in the same cycle; that edge is lost.
      state_next  = COUNT;
      count_next  = '0;
      rcount_next = '0;
      valid_next  = 1'b0;
      ovr_next    = 1'b0;
    end else begin
      case (state_reg)
        COUNT: begin
          if (edge_pulse) begin
            if (at_last) begin
              rcount_next = CNT_FULL;
              count_next  = '0;
              valid_next  = 1'b1;
              state_next  = REPORT;
            end else begin
              count_next = count_reg + COUNT_W'(1);
            end
          end
        end
        REPORT: begin
          if (edge_pulse && at_last && accept) begin
            // Old report leaves as the new one arrives: back-to-back reports.
            rcount_next = CNT_FULL;
            count_next  = '0;
          end else begin
            if (edge_pulse) begin
              if (at_last) begin
                ovr_next = 1'b1;
              end else begin
                count_next = count_reg + COUNT_W'(1);
              end
            end
            if (accept) begin
              valid_next = 1'b0;
              state_next = COUNT;
            end
          end
        end
        default: state_next = COUNT;
      endcase
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= COUNT;
      count_reg  <= '0;
      rcount_reg <= '0;
      valid_reg  <= 1'b0;
      ovr_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      count_reg  <= count_next;
      rcount_reg <= rcount_next;
      valid_reg  <= valid_next;
      ovr_reg    <= ovr_next;
    end
  end

  assign count        = count_reg;
  assign report_count = rcount_reg;
  assign report_valid = valid_reg;
  assign overrun      = ovr_reg;

endmodule
